// File: rtl/div_sequencer_pkg.sv
// Shared types for the multi-cycle divider sequencer.
// State encoding and DIV/DIVU function codes.
package div_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_RUN  = 2'd2,
        S_FIN  = 2'd3
    } state_e;

    localparam logic [5:0] FUNCT_DIV  = 6'h1a;
    localparam logic [5:0] FUNCT_DIVU = 6'h1b;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract division iteration.
// Shifts a dividend bit into the partial remainder and trial-subtracts.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] div_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] shf;
    logic [WIDTH:0] dif;

    // trial subtract; a clear borrow bit means the divisor fits
    always_comb begin
        shf   = {rem_i, bit_i};
        dif   = shf - {1'b0, div_i};
        q_o   = ~dif[WIDTH];
        rem_o = q_o ? dif[WIDTH-1:0] : shf[WIDTH-1:0];
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU sequencer: IDLE -> PREP -> RUN x WIDTH -> FIN.
// Holds the pipeline via stall and pulses done with the HI/LO result.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;

    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] res_hi;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i (rem_q),
        .div_i (div_q),
        .bit_i (quo_q[WIDTH-1]),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    // operand magnitudes and sign-corrected result
    always_comb begin
        a_abs  = (is_signed & a[WIDTH-1]) ? -a : a;
        b_abs  = (is_signed & b[WIDTH-1]) ? -b : b;
        res_lo = dz_q ? '1 : (qneg_q ? -quo_q : quo_q);
        res_hi = rneg_q ? -rem_q : rem_q;
    end

    // FIN shows the fresh result; otherwise the committed HI/LO
    always_comb begin
        done  = resetn & (state_q == S_FIN) & ~flush;
        stall = resetn & (((state_q == S_IDLE) & start & ~flush)
                | (state_q == S_PREP) | (state_q == S_RUN));
        lo    = done ? res_lo : lo_q;
        hi    = done ? res_hi : hi_q;
    end

    // next-state and datapath update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        div_d   = div_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        unique case (state_q)
            S_IDLE: begin
                if (start & ~flush) begin
                    state_d = S_PREP;
                    quo_d   = a_abs;
                    div_d   = b_abs;
                    rem_d   = '0;
                    qneg_d  = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    rneg_d  = is_signed & a[WIDTH-1];
                    dz_d    = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_PREP: begin
                cnt_d = '0;
                if (div_q == '0) begin
                    // remainder becomes |a|, re-signed to a in FIN
                    state_d = S_FIN;
                    dz_d    = 1'b1;
                    rem_d   = quo_q;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                rem_d = step_rem;
                quo_d = {quo_q[WIDTH-2:0], step_q};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = S_FIN;
            end
            S_FIN: begin
                state_d = S_IDLE;
                lo_d    = res_lo;
                hi_d    = res_hi;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
            lo_d    = lo_q;
            hi_d    = hi_q;
        end
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            div_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

endmodule
